// File: rtl/dp_pkg.sv
// Shared encodings for the dp_issue data-processing sequencer.
package dp_pkg;

  // ALU opcodes (instr[24:21]), passed straight through to the ALU.
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;

  // Supported condition codes (instr[31:28]).
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Register-operand shift types (only used when the shifter is built in).
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WB
  } state_t;

  function automatic logic opcode_ok(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_EOR) || (op == OP_SUB) ||
           (op == OP_ADD) || (op == OP_CMP) || (op == OP_ORR);
  endfunction

  function automatic logic cond_ok(input logic [3:0] c);
    return (c == COND_EQ) || (c == COND_NE) || (c == COND_CS) || (c == COND_CC) ||
           (c == COND_HI) || (c == COND_LS) || (c == COND_AL);
  endfunction

endpackage

// File: rtl/dp_op2_gen.sv
// Operand-2 generator: rotated 8-bit immediate or register operand.
// Build option DP_ISSUE_SHIFT_EN adds an LSL/LSR immediate-amount shifter on the
// register path; legality of the shift encoding is checked by the caller.
module dp_op2_gen
  import dp_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            imm,
  input  logic [11:0]     field,
  input  logic [XLEN-1:0] rm_data,
  output logic [XLEN-1:0] op2
);

  logic [2*XLEN-1:0] rot_dbl;
  logic [4:0]        rot_amt;
  logic [XLEN-1:0]   reg_val;

  // Select immediate (rotate right by twice the 4-bit field) or register value.
  always_comb begin
    rot_amt = {field[11:8], 1'b0};
    // Shifting a doubled copy right yields the rotation in the low half.
    rot_dbl = {XLEN'(field[7:0]), XLEN'(field[7:0])} >> rot_amt;
`ifdef DP_ISSUE_SHIFT_EN
    if (field[6:5] == SH_LSR) begin
      reg_val = rm_data >> field[11:7];
    end else begin
      reg_val = rm_data << field[11:7];
    end
`else
    reg_val = rm_data;
`endif
    op2 = imm ? rot_dbl[XLEN-1:0] : reg_val;
  end

endmodule

// File: rtl/dp_issue.sv
// Decode/issue/write-back sequencer for the data-processing ALU.
// One instruction every four cycles: IDLE -> READ -> EXEC -> WB, with the
// retire pulses registered so they appear in the cycle after leaving WB.
// Optional build macro: DP_ISSUE_SHIFT_EN (register operand shifter).
module dp_issue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RF_AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [RF_AW-1:0] rf_raddr1,
  output logic [RF_AW-1:0] rf_raddr2,
  input  logic [XLEN-1:0]  rf_rdata1,
  input  logic [XLEN-1:0]  rf_rdata2,
  output logic [XLEN-1:0]  alu_op1,
  output logic [XLEN-1:0]  alu_op2,
  output logic [3:0]       alu_op,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_zero,
  input  logic             alu_lt,
  input  logic             alu_gt,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             flag_z,
  output logic             flag_lt,
  output logic             flag_gt,
  output logic             done,
  output logic             illegal
);

  import dp_pkg::*;

  state_t state_q, state_d;

  logic [31:0]      instr_q;
  logic             legal_q;
  logic             pass_q;
  logic [XLEN-1:0]  res_q;
  logic [XLEN-1:0]  op1_q, op2_q;
  logic [3:0]       aluop_q;
  logic             z_q, lt_q, gt_q;
  logic             we_q, done_q, illegal_q;
  logic [RF_AW-1:0] waddr_q;
  logic [XLEN-1:0]  wdata_q;

  // Instruction fields of the captured word.
  logic [3:0]  f_cond, f_opc, f_rn, f_rd;
  logic [1:0]  f_class;
  logic        f_imm, f_s;
  logic [11:0] f_op2;

  assign f_cond  = instr_q[31:28];
  assign f_class = instr_q[27:26];
  assign f_imm   = instr_q[25];
  assign f_opc   = instr_q[24:21];
  assign f_s     = instr_q[20];
  assign f_rn    = instr_q[19:16];
  assign f_rd    = instr_q[15:12];
  assign f_op2   = instr_q[11:0];

  logic            op2_ok, legal, cond_pass, is_cmp;
  logic [XLEN-1:0] op2_val;

  dp_op2_gen #(
    .XLEN(XLEN)
  ) u_op2_gen (
    .imm    (f_imm),
    .field  (f_op2),
    .rm_data(rf_rdata2),
    .op2    (op2_val)
  );

  // Legality decode and condition evaluation against the current flags.
  always_comb begin
`ifdef DP_ISSUE_SHIFT_EN
    op2_ok = f_imm || (!f_op2[4] && ((f_op2[6:5] == SH_LSL) || (f_op2[6:5] == SH_LSR)));
`else
    op2_ok = f_imm || (f_op2[11:4] == 8'd0);
`endif
    legal  = (f_class == 2'b00) && opcode_ok(f_opc) && cond_ok(f_cond) && op2_ok;
    is_cmp = (f_opc == OP_CMP);
    case (f_cond)
      COND_EQ: cond_pass = z_q;
      COND_NE: cond_pass = !z_q;
      COND_CS: cond_pass = !lt_q;
      COND_CC: cond_pass = lt_q;
      COND_HI: cond_pass = gt_q;
      COND_LS: cond_pass = !gt_q;
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Next-state logic and register-file read addressing.
  always_comb begin
    state_d     = state_q;
    instr_ready = (state_q == ST_IDLE);
    rf_raddr1   = '0;
    rf_raddr2   = '0;
    case (state_q)
      ST_IDLE: if (instr_valid) state_d = ST_READ;
      ST_READ: begin
        rf_raddr1 = RF_AW'(f_rn);
        rf_raddr2 = RF_AW'(f_op2[3:0]);
        state_d   = legal ? ST_EXEC : ST_WB;
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath latches, flags and registered retire outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      legal_q   <= 1'b0;
      pass_q    <= 1'b0;
      res_q     <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      aluop_q   <= '0;
      z_q       <= 1'b0;
      lt_q      <= 1'b0;
      gt_q      <= 1'b0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      case (state_q)
        ST_IDLE: if (instr_valid) instr_q <= instr;
        ST_READ: begin
          legal_q <= legal;
          // Illegal instructions never reach the ALU, so leave its inputs alone.
          if (legal) begin
            op1_q   <= rf_rdata1;
            op2_q   <= op2_val;
            aluop_q <= f_opc;
          end
        end
        ST_EXEC: begin
          res_q  <= alu_result;
          pass_q <= cond_pass;
          if (cond_pass && (f_s || is_cmp)) begin
            z_q  <= alu_zero;
            lt_q <= alu_lt;
            gt_q <= alu_gt;
          end
        end
        ST_WB: begin
          done_q    <= 1'b1;
          illegal_q <= !legal_q;
          if (legal_q && pass_q && !is_cmp) begin
            we_q    <= 1'b1;
            waddr_q <= RF_AW'(f_rd);
            wdata_q <= res_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_op1  = op1_q;
  assign alu_op2  = op2_q;
  assign alu_op   = aluop_q;
  assign flag_z   = z_q;
  assign flag_lt  = lt_q;
  assign flag_gt  = gt_q;
  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign done     = done_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_dp_issue.sv
// Directed self-checking bench for dp_issue with a behavioural ALU and
// register file around the DUT.
module tb_dp_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  rf_raddr1, rf_raddr2, rf_waddr, alu_op;
  logic [31:0] rf_rdata1, rf_rdata2, alu_op1, alu_op2, alu_result, rf_wdata;
  logic        alu_zero, alu_lt, alu_gt, rf_we;
  logic        flag_z, flag_lt, flag_gt, done, illegal;

  int compared   = 0;
  int mismatched = 0;

  // Register file plus write log; preload port used by the tasks.
  logic [31:0] rf [16];
  logic        pl_we = 1'b0;
  logic [3:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic [3:0]  wlog_a [32];
  logic [31:0] wlog_d [32];
  int          wcount = 0;

  always #5 clk = ~clk;

  dp_issue dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .rf_raddr1  (rf_raddr1),
    .rf_raddr2  (rf_raddr2),
    .rf_rdata1  (rf_rdata1),
    .rf_rdata2  (rf_rdata2),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_lt     (alu_lt),
    .alu_gt     (alu_gt),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .flag_z     (flag_z),
    .flag_lt    (flag_lt),
    .flag_gt    (flag_gt),
    .done       (done),
    .illegal    (illegal)
  );

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  // Behavioural ALU.
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_op1 & alu_op2;
      4'b0001: alu_result = alu_op1 ^ alu_op2;
      4'b0010: alu_result = alu_op1 - alu_op2;
      4'b0100: alu_result = alu_op1 + alu_op2;
      4'b1010: alu_result = alu_op1 - alu_op2;
      4'b1100: alu_result = alu_op1 | alu_op2;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 32'd0);
    alu_lt   = (alu_op1 < alu_op2);
    alu_gt   = (alu_op1 > alu_op2);
  end

  always @(posedge clk) begin
    if (pl_we) rf[pl_addr] <= pl_data;
    if (rf_we) begin
      rf[rf_waddr]   <= rf_wdata;
      wlog_a[wcount] <= rf_waddr;
      wlog_d[wcount] <= rf_wdata;
      wcount         <= wcount + 1;
    end
  end

  task automatic set_reg(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_we = 1'b0;
  endtask

  task automatic issue(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      compared++; mismatched++;
      $display("FAIL issue_ready: instr_ready=%b required 1", instr_ready);
    end
    instr = w; instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  // Issue one instruction and observe six cycles: done latency (negedge count
  // after the accept edge), any write, illegal, and ALU inputs in EXEC.
  task automatic run_instr(input logic [31:0] w, output int lat, output logic we_any,
                           output logic [3:0] wa, output logic [31:0] wd, output logic ill,
                           output logic [3:0] xop, output logic [31:0] xop2);
    lat = 0; we_any = 0; wa = 0; wd = 0; ill = 0; xop = 0; xop2 = 0;
    issue(w);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 2) begin xop = alu_op; xop2 = alu_op2; end
      if (rf_we) begin we_any = 1; wa = rf_waddr; wd = rf_wdata; end
      if (done && lat == 0) begin lat = k; ill = illegal; end
    end
  endtask

  int lat; logic we_any, ill; logic [3:0] wa, xop; logic [31:0] wd, xop2;

  task automatic test_reset();
    rst = 1'b1; instr = '0; instr_valid = 1'b0;
    #2;
    compared++;
    if ({instr_ready, rf_we, done, illegal} !== 4'b1000) begin mismatched++;
      $display("FAIL reset_ctrl: rdy/we/done/ill=%b required 1000",
               {instr_ready, rf_we, done, illegal}); end
    compared++;
    if ({flag_z, flag_lt, flag_gt} !== 3'b000) begin mismatched++;
      $display("FAIL reset_flags: %b required 000", {flag_z, flag_lt, flag_gt}); end
    compared++;
    if ({alu_op1, alu_op2, alu_op, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata} !== '0) begin
      mismatched++;
      $display("FAIL reset_data: op1=%h op2=%h op=%h wa=%h wd=%h required all 0",
               alu_op1, alu_op2, alu_op, rf_waddr, rf_wdata); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 16; i++) set_reg(i[3:0], 32'd0);
  endtask

  task automatic test_add();
    set_reg(4'd2, 32'd10);
    run_instr(32'hE282_1005, lat, we_any, wa, wd, ill, xop, xop2);
    compared++;
    if (xop !== 4'b0100 || xop2 !== 32'd5) begin mismatched++;
      $display("FAIL add_alu: op=%b op2=%0d required 0100/5", xop, xop2); end
    compared++;
    if (lat !== 4 || ill !== 1'b0) begin mismatched++;
      $display("FAIL add_latency: done at %0d ill=%b required 4/0", lat, ill); end
    compared++;
    if (we_any !== 1'b1 || wa !== 4'd1 || wd !== 32'd15) begin mismatched++;
      $display("FAIL add_write: we=%b wa=%0d wd=%0d required 1/1/15", we_any, wa, wd); end
    compared++;
    if ({flag_z, flag_lt, flag_gt} !== 3'b000) begin mismatched++;
      $display("FAIL add_flags: %b required 000", {flag_z, flag_lt, flag_gt}); end
  endtask

  task automatic test_orr_rotate();
    run_instr(32'hE380_34FF, lat, we_any, wa, wd, ill, xop, xop2);
    compared++;
    if (xop !== 4'b1100 || xop2 !== 32'hFF00_0000) begin mismatched++;
      $display("FAIL orr_alu: op=%b op2=%h required 1100/ff000000", xop, xop2); end
    compared++;
    if (we_any !== 1'b1 || wa !== 4'd3 || wd !== 32'hFF00_0000 || lat !== 4) begin
      mismatched++;
      $display("FAIL orr_write: we=%b wa=%0d wd=%h lat=%0d required 1/3/ff000000/4",
               we_any, wa, wd, lat); end
  endtask

  task automatic test_cmp_cond();
    set_reg(4'd1, 32'd7);
    set_reg(4'd2, 32'd7);
    run_instr(32'hE151_0002, lat, we_any, wa, wd, ill, xop, xop2);
    compared++;
    if ({flag_z, flag_lt, flag_gt} !== 3'b100) begin mismatched++;
      $display("FAIL cmp_flags: %b required 100", {flag_z, flag_lt, flag_gt}); end
    compared++;
    if (we_any !== 1'b0 || lat !== 4) begin mismatched++;
      $display("FAIL cmp_nowrite: we=%b lat=%0d required 0/4", we_any, lat); end
    run_instr(32'h1282_1005, lat, we_any, wa, wd, ill, xop, xop2);
    compared++;
    if (we_any !== 1'b0 || lat !== 4 || ill !== 1'b0) begin mismatched++;
      $display("FAIL addne_skip: we=%b lat=%0d ill=%b required 0/4/0", we_any, lat, ill); end
    compared++;
    if ({flag_z, flag_lt, flag_gt} !== 3'b100 || rf[1] !== 32'd7) begin mismatched++;
      $display("FAIL addne_state: flags=%b r1=%0d required 100/7",
               {flag_z, flag_lt, flag_gt}, rf[1]); end
  endtask

  task automatic test_illegal();
    run_instr(32'hEA00_0000, lat, we_any, wa, wd, ill, xop, xop2);
    compared++;
    if (lat !== 3 || ill !== 1'b1) begin mismatched++;
      $display("FAIL illegal_pulse: done at %0d ill=%b required 3/1", lat, ill); end
    compared++;
    if (we_any !== 1'b0 || {flag_z, flag_lt, flag_gt} !== 3'b100 || instr_ready !== 1'b1)
    begin mismatched++;
      $display("FAIL illegal_state: we=%b flags=%b rdy=%b required 0/100/1",
               we_any, {flag_z, flag_lt, flag_gt}, instr_ready); end
  endtask

  // ADD R1,R2,R1,LSL #1: only legal with the operand shifter built in.
  task automatic test_reg_shift();
    set_reg(4'd1, 32'd3);
    set_reg(4'd2, 32'd10);
    run_instr(32'hE082_1081, lat, we_any, wa, wd, ill, xop, xop2);
    compared++;
`ifdef DP_ISSUE_SHIFT_EN
    if (lat !== 4 || ill !== 1'b0 || we_any !== 1'b1 || wa !== 4'd1 || wd !== 32'd16) begin
      mismatched++;
      $display("FAIL reg_shift: lat=%0d ill=%b we=%b wa=%0d wd=%0d required 4/0/1/1/16",
               lat, ill, we_any, wa, wd); end
`else
    if (lat !== 3 || ill !== 1'b1 || we_any !== 1'b0) begin mismatched++;
      $display("FAIL reg_shift: lat=%0d ill=%b we=%b required 3/1/0", lat, ill, we_any); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [3];
    logic [11:0] rdy;
    int idx, w0;
    prog[0] = 32'hE282_4001;  // R4 = R2 + 1
    prog[1] = 32'hE282_5002;  // R5 = R2 + 2
    prog[2] = 32'hE284_6003;  // R6 = R4 + 3 (uses R4 just written)
    set_reg(4'd2, 32'd10);
    w0 = wcount; idx = 0; rdy = '0;
    instr = prog[0]; instr_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c < 12) rdy[c] = instr_ready;
      if (instr_ready && instr_valid) begin
        @(posedge clk);
        #1;
        idx++;
        if (idx < 3) instr = prog[idx];
        else instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    compared++;
    if (rdy !== 12'h111) begin mismatched++;
      $display("FAIL b2b_ready: pattern=%h required 111", rdy); end
    compared++;
    if (wcount - w0 !== 3) begin mismatched++;
      $display("FAIL b2b_count: writes=%0d required 3", wcount - w0); end
    else begin
      compared++;
      if (wlog_a[w0] !== 4'd4 || wlog_d[w0] !== 32'd11 || wlog_a[w0+1] !== 4'd5 ||
          wlog_d[w0+1] !== 32'd12 || wlog_a[w0+2] !== 4'd6 || wlog_d[w0+2] !== 32'd14)
      begin mismatched++;
        $display("FAIL b2b_order: (%0d,%0d)(%0d,%0d)(%0d,%0d) required (4,11)(5,12)(6,14)",
                 wlog_a[w0], wlog_d[w0], wlog_a[w0+1], wlog_d[w0+1],
                 wlog_a[w0+2], wlog_d[w0+2]); end
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    set_reg(4'd1, 32'h55);
    set_reg(4'd2, 32'd10);
    issue(32'hE282_1005);
    @(negedge clk);  // READ
    @(negedge clk);  // EXEC
    rst = 1'b1;
    #1;
    compared++;
    if (instr_ready !== 1'b1 || alu_op !== 4'd0 || alu_op2 !== 32'd0 || rf_we !== 1'b0 ||
        done !== 1'b0 || flag_z !== 1'b0) begin mismatched++;
      $display("FAIL rst_mid: rdy=%b op=%b op2=%h we=%b done=%b z=%b required 1/0/0/0/0/0",
               instr_ready, alu_op, alu_op2, rf_we, done, flag_z); end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rf_we || done) seen = 1'b1;
    end
    compared++;
    if (seen !== 1'b0 || rf[1] !== 32'h55) begin mismatched++;
      $display("FAIL rst_drop: activity=%b r1=%h required 0/55", seen, rf[1]); end
    run_instr(32'hE282_7005, lat, we_any, wa, wd, ill, xop, xop2);
    compared++;
    if (lat !== 4 || we_any !== 1'b1 || wa !== 4'd7 || wd !== 32'd15) begin mismatched++;
      $display("FAIL rst_resume: lat=%0d we=%b wa=%0d wd=%0d required 4/1/7/15",
               lat, we_any, wa, wd); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_orr_rotate();
    test_cmp_cond();
    test_illegal();
    test_reg_shift();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
